nested_loop_counter: RTL and testbench

//  Parametrised successor to the single-level counter: NUM_LEVELS nested loop counters with

---
 rtl/nested_loop_cnt_pkg.sv | 18 +
 rtl/loop_cnt_level.sv | 63 ++++++
 rtl/nested_loop_counter.sv | 114 +++++++++++
 tb/tb_nested_loop_counter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nested_loop_cnt_pkg.sv
// Shared types and slicing helpers for the nested loop counter.
// Packing: level i of any packed per-level vector lives at [i*BW +: BW].
package nested_loop_cnt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_BW         = 8;
  localparam int DEF_NUM_LEVELS = 3;

  function automatic int lvl_lsb(input int level, input int bw);
    return level * bw;
  endfunction

endpackage

// File: rtl/loop_cnt_level.sv
// One level of the nested counter: count register, latched bound/base, carry and wrap flag.
// Latency: count and wrap update one cycle after the controls; carry_out is combinational.
module loop_cnt_level
  import nested_loop_cnt_pkg::*;
#(
  parameter int BW = DEF_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          zero,
  input  logic          adv,
  input  logic          wrap_all,
  input  logic          carry_in,
  input  logic [BW-1:0] bound,
  input  logic [BW-1:0] base,
  output logic [BW-1:0] count,
  output logic          carry_out,
  output logic          wrap
);

  logic [BW-1:0] bound_q;
  logic [BW-1:0] base_q;
  logic          at_bound;

`ifdef NESTED_LOOP_CNT_PRELOAD_EN
  // A base above the bound makes the level single-valued at base, so treat it as always at bound.
  assign at_bound = (count == bound_q) || (base_q > bound_q);
`else
  assign at_bound = (count == bound_q);
`endif

  assign carry_out = carry_in & at_bound;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      bound_q <= '0;
      base_q  <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (zero) begin
        count <= '0;
      end else if (load) begin
        bound_q <= bound;
        base_q  <= base;
        count   <= base;
      end else if (adv && carry_in) begin
        // Wrap by compare only: bound may be all-ones, natural overflow is never relied on.
        if (at_bound) begin
          count <= base_q;
          wrap  <= 1'b1;
        end else begin
          count <= count + BW'(1);
        end
      end else if (wrap_all) begin
        wrap <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nested_loop_counter.sv
// NUM_LEVELS nested loop counters (level 0 innermost) with start/done handshake and wrap flags.
// Latency: start -> RUN with count at start value next cycle; last advance -> one DONE cycle -> IDLE.
// Optional NESTED_LOOP_CNT_PRELOAD_EN adds a base input so levels start/wrap to base instead of 0.
module nested_loop_counter
  import nested_loop_cnt_pkg::*;
#(
  parameter int BW         = DEF_BW,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     en,
  input  logic [NUM_LEVELS*BW-1:0] bound,
`ifdef NESTED_LOOP_CNT_PRELOAD_EN
  input  logic [NUM_LEVELS*BW-1:0] base,
`endif
  output logic [NUM_LEVELS*BW-1:0] count,
  output logic [NUM_LEVELS-1:0]    wrap,
  output logic                     last,
  output logic                     busy,
  output logic                     done
);

  state_t                  state, state_nxt;
  logic                    load, zero, adv, wrap_all;
  logic [NUM_LEVELS:0]     carry;
  logic [NUM_LEVELS*BW-1:0] base_vec;

`ifdef NESTED_LOOP_CNT_PRELOAD_EN
  assign base_vec = base;
`else
  assign base_vec = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    zero      = 1'b0;
    adv       = 1'b0;
    wrap_all  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          load      = 1'b1;
        end else begin
          zero = 1'b1;
        end
      end
      S_RUN: begin
        if (en) begin
          if (carry[NUM_LEVELS]) begin
            state_nxt = S_DONE;
            wrap_all  = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        zero      = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        zero      = 1'b1;
      end
    endcase
    // Abort wins over everything that would otherwise happen this cycle.
    if (clear) begin
      state_nxt = S_IDLE;
      load      = 1'b0;
      adv       = 1'b0;
      wrap_all  = 1'b0;
      zero      = 1'b1;
    end
  end

  // carry[NUM_LEVELS] is high exactly when every level sits at its latched bound.
  assign carry[0] = 1'b1;
  assign last     = (state == S_RUN) && carry[NUM_LEVELS];
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_lvl
    loop_cnt_level #(
      .BW(BW)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .zero      (zero),
      .adv       (adv),
      .wrap_all  (wrap_all),
      .carry_in  (carry[i]),
      .bound     (bound[lvl_lsb(i, BW) +: BW]),
      .base      (base_vec[lvl_lsb(i, BW) +: BW]),
      .count     (count[lvl_lsb(i, BW) +: BW]),
      .carry_out (carry[i+1]),
      .wrap      (wrap[i])
    );
  end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter (3 levels x 8 bits); base port only with NESTED_LOOP_CNT_PRELOAD_EN.
module tb_nested_loop_counter;

  logic        clk = 1'b0;
  logic        rst, start, clear, en;
  logic [23:0] bound;
  logic [23:0] count;
  logic [2:0]  wrap;
  logic        last, busy, done;
`ifdef NESTED_LOOP_CNT_PRELOAD_EN
  logic [23:0] base;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nested_loop_counter #(.BW(8), .NUM_LEVELS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .clear (clear),
    .en    (en),
    .bound (bound),
`ifdef NESTED_LOOP_CNT_PRELOAD_EN
    .base  (base),
`endif
    .count (count),
    .wrap  (wrap),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic        rst, start, clear, en;
    logic [23:0] bound;
    logic [23:0] ec;
    logic [2:0]  ew;
    logic        el, eb, ed;
  } vec_t;

  vec_t vt[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [23:0] ec, input logic [2:0] ew,
                           input logic el, input logic eb, input logic ed);
    chk({nm, ".count"}, 64'(count), 64'(ec));
    chk({nm, ".wrap"},  64'(wrap),  64'(ew));
    chk({nm, ".last"},  64'(last),  64'(el));
    chk({nm, ".busy"},  64'(busy),  64'(eb));
    chk({nm, ".done"},  64'(done),  64'(ed));
  endtask

  // Mixed-radix decomposition of the iteration index k into per-level counts.
  function automatic logic [23:0] exp_cnt(input logic [23:0] b, input int k);
    int r0, r1, r2, c0, c1, c2;
    r0 = int'(b[7:0]) + 1;
    r1 = int'(b[15:8]) + 1;
    r2 = int'(b[23:16]) + 1;
    c0 = k % r0;
    c1 = (k / r0) % r1;
    c2 = (k / (r0 * r1)) % r2;
    return {c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  // Level i wraps on reaching iteration k when k is a multiple of the product of radices 0..i.
  function automatic logic [2:0] exp_wrap(input logic [23:0] b, input int k);
    int p0, p1, p2;
    p0 = int'(b[7:0]) + 1;
    p1 = p0 * (int'(b[15:8]) + 1);
    p2 = p1 * (int'(b[23:16]) + 1);
    return {(k % p2) == 0, (k % p1) == 0, (k % p0) == 0};
  endfunction

  task automatic run_sweep(input string nm, input logic [23:0] b, input bit rand_en, input bit noisy);
    int  tot, k, cyc;
    bit  en_b;
    tot = (int'(b[7:0]) + 1) * (int'(b[15:8]) + 1) * (int'(b[23:16]) + 1);
    start = 1'b1; clear = 1'b0; en = 1'b0; bound = b;
    step();
    start = 1'b0; bound = ~b;
    check_all({nm, "_start"}, 24'h0, 3'b0, tot == 1, 1'b1, 1'b0);
    k = 0; cyc = 0;
    while (k < tot && cyc < 4000) begin
      en_b = rand_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      en   = en_b;
      if (noisy) begin
        start = ($urandom_range(0, 1) == 1);
        bound = 24'($urandom);
      end
      step();
      cyc++;
      if (en_b) begin
        k++;
        if (k == tot) check_all({nm, "_done"}, exp_cnt(b, tot - 1), 3'b111, 1'b0, 1'b1, 1'b1);
        else          check_all(nm, exp_cnt(b, k), exp_wrap(b, k), k == tot - 1, 1'b1, 1'b0);
      end else begin
        check_all({nm, "_hold"}, exp_cnt(b, k), 3'b0, k == tot - 1, 1'b1, 1'b0);
      end
    end
    en = 1'b0; start = 1'b0;
    chk({nm, "_advances"}, 64'(k), 64'(tot));
    step();
    check_all({nm, "_idle"}, 24'h0, 3'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; en = 1'b0; bound = '0;
`ifdef NESTED_LOOP_CNT_PRELOAD_EN
    base = '0;
`endif
    step();
    step();

    //          rst   start clear en    bound        count        wrap    last  busy  done
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h010203, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h010203, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b111, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000001, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000001, 24'h000000, 3'b000, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000001, 3'b000, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h050505, 24'h000001, 3'b000, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000001, 3'b111, 1'b0, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000001, 24'h000000, 3'b000, 1'b0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; start = vt[i].start; clear = vt[i].clear; en = vt[i].en; bound = vt[i].bound;
      step();
      check_all($sformatf("vec%0d", i), vt[i].ec, vt[i].ew, vt[i].el, vt[i].eb, vt[i].ed);
    end
    rst = 1'b0; start = 1'b0; clear = 1'b0; en = 1'b0;

    run_sweep("full124", 24'h010203, 1'b0, 1'b0);
    run_sweep("rand222", 24'h020202, 1'b1, 1'b0);
    run_sweep("noisy111", 24'h010101, 1'b1, 1'b1);

    // Abort at {1,1,1} with start and en also high, then a fresh sweep one cycle later.
    start = 1'b1; bound = 24'h020202;
    step();
    start = 1'b0; en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("pre_clear%0d.count", k), 64'(count), 64'(exp_cnt(24'h020202, k)));
    end
    chk("at111.count", 64'(count), 64'h010101);
    start = 1'b1; clear = 1'b1; en = 1'b1;
    step();
    start = 1'b0; clear = 1'b0; en = 1'b0;
    check_all("clear", 24'h0, 3'b0, 1'b0, 1'b0, 1'b0);
    run_sweep("fresh", 24'h000102, 1'b0, 1'b0);

    // Reset in the middle of a sweep.
    start = 1'b1; bound = 24'h020202;
    step();
    start = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("pre_rst.count", 64'(count), 64'(exp_cnt(24'h020202, 5)));
    rst = 1'b1;
    step();
    check_all("rst_mid", 24'h0, 3'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b0;
    step();
    check_all("rst_after", 24'h0, 3'b0, 1'b0, 1'b0, 1'b0);

    run_sweep("max255", 24'h0001FF, 1'b0, 1'b0);

`ifdef NESTED_LOOP_CNT_PRELOAD_EN
    start = 1'b1; bound = 24'h0001FF; base = 24'h0000FA;
    step();
    start = 1'b0; base = '0;
    check_all("pre_start", 24'h0000FA, 3'b0, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 12) begin
        check_all("pre_done", 24'h0001FF, 3'b111, 1'b0, 1'b1, 1'b1);
      end else begin
        check_all($sformatf("pre%0d", k), {8'h00, 8'(k / 6), 8'(250 + k % 6)},
                  {2'b00, (k % 6) == 0}, k == 11, 1'b1, 1'b0);
      end
    end
    en = 1'b0;
    step();
    check_all("pre_idle", 24'h0, 3'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
